// File: rtl/pkt_xi_rx_arb.sv
// -----------------------------------------------------------------------------
// pkt_xi_rx_arb
//   Node-side receiver for the X-direction input links of a mesh connection
//   bundle. It merges N_PORT single-flit valid/ready channels into one stream
//   and buffers the accepted flits in a small FIFO that feeds the routing core.
//   The Y-direction side uses the same block unchanged.
//
//   Arbitration is QoS-first, then round-robin within the winning class.
//   A qos=0 requester that has been stalled for STARVE_LIM cycles is promoted
//   into the high class until it is served, which bounds low-class waiting.
//
// Ports
//   clk        clock
//   rst_n      synchronous reset, active low (drops all buffered flits)
//   xi_vld     per-link valid
//   xi_rdy     per-link ready, at most one bit set
//   xi_qos     per-link QoS (1 = high class)
//   xi_type    per-link 2-bit packet type          (flattened, link i at [2*i +: 2])
//   xi_src     per-link source node ID             (flattened, ID_W per link)
//   xi_tgt     per-link target node ID             (flattened, ID_W per link)
//   xi_data    per-link payload                    (flattened, FLIT_W per link)
//   out_vld    FIFO head valid
//   out_rdy    routing core accepts the head
//   out_qos/out_type/out_src/out_tgt/out_data   head flit fields
//   out_port   index of the link the head flit arrived on
//   occ        FIFO occupancy
// -----------------------------------------------------------------------------
module pkt_xi_rx_arb #(
   parameter  int N_PORT     = 7,
   parameter  int ID_W       = 6,
   parameter  int FLIT_W     = 8,
   parameter  int DEPTH      = 4,
   parameter  int STARVE_LIM = 15,
   localparam int PORT_W     = (N_PORT > 1) ? $clog2(N_PORT) : 1,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_PORT-1:0]        xi_vld,
   output logic [N_PORT-1:0]        xi_rdy,
   input  logic [N_PORT-1:0]        xi_qos,
   input  logic [2*N_PORT-1:0]      xi_type,
   input  logic [ID_W*N_PORT-1:0]   xi_src,
   input  logic [ID_W*N_PORT-1:0]   xi_tgt,
   input  logic [FLIT_W*N_PORT-1:0] xi_data,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic                     out_qos,
   output logic [1:0]               out_type,
   output logic [ID_W-1:0]          out_src,
   output logic [ID_W-1:0]          out_tgt,
   output logic [FLIT_W-1:0]        out_data,
   output logic [PORT_W-1:0]        out_port,
   output logic [CNT_W-1:0]         occ
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIM + 1);

   typedef struct packed {
      logic              qos;
      logic [1:0]        typ;
      logic [ID_W-1:0]   src;
      logic [ID_W-1:0]   tgt;
      logic [FLIT_W-1:0] data;
      logic [PORT_W-1:0] port;
   } flit_t;

   // ---------------------------------------------------------------- state
   logic [SW-1:0]     starve_cnt [N_PORT];
   logic [PORT_W-1:0] rr_ptr;
   flit_t             mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  count;

   // ---------------------------------------------------------------- arbitration
   logic [N_PORT-1:0] starved;
   logic [N_PORT-1:0] hi_req;
   logic [N_PORT-1:0] lo_req;
   logic [N_PORT-1:0] req;
   logic              gnt_found;
   logic [PORT_W-1:0] gnt_idx;
   logic              space_ok;
   logic              push;
   logic              pop;
   flit_t             wr_flit;

   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise a path that skips the write infers a latch.
      starved = '0;
      for (int i = 0; i < N_PORT; i++) begin
         starved[i] = (starve_cnt[i] == SW'(STARVE_LIM));
      end
      hi_req = xi_vld & (xi_qos | starved);
      lo_req = xi_vld & ~hi_req;
      req    = (|hi_req) ? hi_req : lo_req;
   end

   // First requester found scanning rr_ptr+1, rr_ptr+2, ... modulo N_PORT,
   // so the last winner has the lowest priority next time.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= N_PORT; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_PORT) begin
            idx = idx - N_PORT;
         end
         if (!gnt_found && req[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = PORT_W'(idx);
         end
      end
   end

   // Space is judged on the registered count only: a pop in the same cycle
   // does not open a slot, which keeps out_rdy off the xi_rdy path.
   assign space_ok = (count != CNT_W'(DEPTH));

   always_comb begin
      xi_rdy = '0;
      if (rst_n && gnt_found && space_ok) begin
         xi_rdy[gnt_idx] = 1'b1;
      end
   end

   assign push = |xi_rdy;
   assign pop  = out_vld & out_rdy;

   always_comb begin
      wr_flit.qos  = xi_qos[gnt_idx];
      wr_flit.typ  = xi_type[2*gnt_idx +: 2];
      wr_flit.src  = xi_src[ID_W*gnt_idx +: ID_W];
      wr_flit.tgt  = xi_tgt[ID_W*gnt_idx +: ID_W];
      wr_flit.data = xi_data[FLIT_W*gnt_idx +: FLIT_W];
      wr_flit.port = gnt_idx;
   end

   // ---------------------------------------------------------------- starvation
   // A stalled requester counts up and saturates; being served or dropping
   // valid clears the count.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         for (int i = 0; i < N_PORT; i++) begin
            starve_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_PORT; i++) begin
            if (xi_vld[i] && !xi_rdy[i]) begin
               if (starve_cnt[i] != SW'(STARVE_LIM)) begin
                  starve_cnt[i] <= starve_cnt[i] + 1'b1;
               end
            end else begin
               starve_cnt[i] <= '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr_ptr <= PORT_W'(N_PORT - 1);
         // NOTE: the storage array is cleared too, so head fields read as zero
         // after reset instead of stale flits from before it.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_flit;
            wr_ptr      <= wr_ptr + 1'b1;
            rr_ptr      <= gnt_idx;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign out_vld  = (count != '0);
   assign out_qos  = mem[rd_ptr].qos;
   assign out_type = mem[rd_ptr].typ;
   assign out_src  = mem[rd_ptr].src;
   assign out_tgt  = mem[rd_ptr].tgt;
   assign out_data = mem[rd_ptr].data;
   assign out_port = mem[rd_ptr].port;
   assign occ      = count;

endmodule

// File: tb/tb_pkt_xi_rx_arb.sv
module tb_pkt_xi_rx_arb;

   localparam int N     = 7;
   localparam int ID_W  = 6;
   localparam int FW    = 8;
   localparam int DEPTH = 4;
   localparam int SL    = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      vld;
   logic [N-1:0]      qos;
   logic [N-1:0]      xi_rdy;
   logic [2*N-1:0]    xi_type;
   logic [ID_W*N-1:0] xi_src;
   logic [ID_W*N-1:0] xi_tgt;
   logic [FW*N-1:0]   xi_data;
   logic              out_vld;
   logic              out_rdy;
   logic              out_qos;
   logic [1:0]        out_type;
   logic [ID_W-1:0]   out_src;
   logic [ID_W-1:0]   out_tgt;
   logic [FW-1:0]     out_data;
   logic [2:0]        out_port;
   logic [2:0]        occ;

   logic [FW-1:0]     pdata [N];
   logic [1:0]        ptype [N];
   logic [ID_W-1:0]   psrc  [N];
   logic [ID_W-1:0]   ptgt  [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      xi_type = '0;
      xi_src  = '0;
      xi_tgt  = '0;
      xi_data = '0;
      for (int i = 0; i < N; i++) begin
         xi_type[2*i +: 2]       = ptype[i];
         xi_src[ID_W*i +: ID_W]  = psrc[i];
         xi_tgt[ID_W*i +: ID_W]  = ptgt[i];
         xi_data[FW*i +: FW]     = pdata[i];
      end
   end

   pkt_xi_rx_arb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .xi_vld   (vld),
      .xi_rdy   (xi_rdy),
      .xi_qos   (qos),
      .xi_type  (xi_type),
      .xi_src   (xi_src),
      .xi_tgt   (xi_tgt),
      .xi_data  (xi_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_qos  (out_qos),
      .out_type (out_type),
      .out_src  (out_src),
      .out_tgt  (out_tgt),
      .out_data (out_data),
      .out_port (out_port),
      .occ      (occ)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [FW-1:0] def_data(input int i);
      return (i == 3) ? 8'hA5 : FW'(8'h10 + i);
   endfunction

   logic [11:0] sb [$];
   logic [11:0] exp_e;
   logic [N-1:0] granted;
   int          wait_c [N];
   int          max_wait;
   int          model_cnt;
   bit          drain;
   bit          push_seen;
   bit          pop_seen;

   initial begin
      for (int i = 0; i < N; i++) begin
         pdata[i] = def_data(i);
         ptype[i] = 2'(i);
         psrc[i]  = ID_W'(6'h20 + i);
         ptgt[i]  = ID_W'(6'h01 + i);
      end

      // ---- reset state: ready held low while in reset, even with requests
      rst_n   = 1'b0;
      vld     = 7'h7F;
      qos     = '0;
      out_rdy = 1'b1;
      tick();
      check("rst_rdy", xi_rdy, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_occ", occ, 0);

      // ---- T1: all ports valid, low class -> 0,1,...,6,0
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t1_rdy", xi_rdy, 32'(1) << (k % 7));
         tick();
         check("t1_out_vld", out_vld, 1);
         check("t1_port", out_port, k % 7);
         check("t1_data", out_data, def_data(k % 7));
         if (k == 2) begin
            check("t1_src", out_src, 6'h22);
            check("t1_tgt", out_tgt, 6'h03);
            check("t1_type", out_type, 2);
            check("t1_qos", out_qos, 0);
         end
      end
      vld = '0;
      tick();
      check("t1_drain_occ", occ, 0);
      check("t1_drain_vld", out_vld, 0);

      // ---- T2: port 4 high, port 0 low -> port 0 promoted after 15 stalls
      do_reset();
      vld = 7'h11;
      qos = 7'h10;
      for (int c = 0; c < 17; c++) begin
         #1;
         check("t2_rdy", xi_rdy, (c == 15) ? 32'h01 : 32'h10);
         tick();
         check("t2_port", out_port, (c == 15) ? 0 : 4);
      end
      vld = '0;
      qos = '0;
      tick();

      // ---- T3: FIFO fills to DEPTH, no ready until a pop has landed
      do_reset();
      out_rdy = 1'b0;
      vld     = 7'h1F;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("t3_rdy", xi_rdy, 32'(1) << c);
         tick();
      end
      #1;
      check("t3_full_rdy", xi_rdy, 0);
      check("t3_full_occ", occ, 4);
      tick();
      check("t3_hold_occ", occ, 4);
      check("t3_hold_port", out_port, 0);
      out_rdy = 1'b1;
      #1;
      check("t3_pop_rdy", xi_rdy, 0);
      tick();
      check("t3_occ_a", occ, 3);
      check("t3_port_a", out_port, 1);
      #1;
      check("t3_resume_rdy", xi_rdy, 32'h10);
      tick();
      check("t3_occ_b", occ, 3);
      check("t3_port_b", out_port, 2);
      #1;
      check("t3_next_rdy", xi_rdy, 32'h01);
      tick();
      vld = '0;
      for (int c = 0; c < 3; c++) tick();
      check("t3_drain_occ", occ, 0);

      // ---- T4: push and pop in the same cycle at count=2
      do_reset();
      out_rdy = 1'b0;
      vld     = 7'h02;
      #1;
      check("t4_rdy1", xi_rdy, 32'h02);
      tick();
      vld = 7'h04;
      #1;
      check("t4_rdy2", xi_rdy, 32'h04);
      tick();
      check("t4_occ2", occ, 2);
      vld     = 7'h08;
      out_rdy = 1'b1;
      #1;
      check("t4_rdy3", xi_rdy, 32'h08);
      tick();
      check("t4_occ_same", occ, 2);
      check("t4_head2", out_port, 2);
      vld = '0;
      tick();
      check("t4_occ1", occ, 1);
      check("t4_head3", out_port, 3);
      check("t4_data3", out_data, 8'hA5);
      tick();
      check("t4_empty", out_vld, 0);

      // ---- T5: reset with 3 flits buffered
      do_reset();
      out_rdy = 1'b0;
      vld     = 7'h07;
      for (int c = 0; c < 3; c++) tick();
      check("t5_occ3", occ, 3);
      rst_n = 1'b0;
      vld   = 7'h7F;
      #1;
      check("t5_rst_rdy", xi_rdy, 0);
      tick();
      rst_n = 1'b1;
      check("t5_out_vld", out_vld, 0);
      check("t5_occ", occ, 0);
      vld = '0;
      #1;
      check("t5_idle_rdy", xi_rdy, 0);
      vld = 7'h7F;
      #1;
      check("t5_first_gnt", xi_rdy, 32'h01);
      tick();
      check("t5_port", out_port, 0);
      check("t5_occ1", occ, 1);
      vld     = '0;
      out_rdy = 1'b1;
      tick();

      // ---- T6: random traffic against a scoreboard, sticky valid
      do_reset();
      model_cnt = 0;
      max_wait  = 0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      for (int cyc = 0; cyc < 10030; cyc++) begin
         drain = (cyc >= 10000);
         for (int i = 0; i < N; i++) begin
            if (!vld[i] && !drain && $urandom_range(0, 2) == 0) begin
               vld[i]   = 1'b1;
               qos[i]   = ($urandom_range(0, 3) == 0);
               pdata[i] = FW'($urandom);
            end
         end
         out_rdy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         check("t6_onehot", $onehot0(xi_rdy), 1);
         check("t6_rdy_vld", xi_rdy & ~vld, 0);
         check("t6_occ", occ, model_cnt);
         check("t6_out_vld", out_vld, model_cnt != 0);
         if (model_cnt == DEPTH) check("t6_full_rdy", xi_rdy, 0);
         pop_seen = out_vld && out_rdy;
         if (pop_seen) begin
            if (sb.size() == 0) begin
               check("t6_underflow", 1, 0);
            end else begin
               exp_e = sb.pop_front();
               check("t6_head", {out_qos, out_port, out_data}, exp_e);
            end
         end
         push_seen = 1'b0;
         granted   = vld & xi_rdy;
         for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
               sb.push_back({qos[i], 3'(i), pdata[i]});
               push_seen = 1'b1;
            end
            if (vld[i] && !xi_rdy[i] && !qos[i]) begin
               if (model_cnt != DEPTH) wait_c[i]++;
               if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end else begin
               wait_c[i] = 0;
            end
         end
         model_cnt = model_cnt + int'(push_seen) - int'(pop_seen);
         tick();
         vld = vld & ~granted;
      end
      check("t6_sb_empty", sb.size(), 0);
      check("t6_end_occ", occ, 0);
      check("t6_wait_bound", max_wait <= SL + N, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
